// File: rtl/puertas_if.sv
// puertas_if -- link between the door control logic and the door actuator.
//
// Handshake: this is a level-based command link with no valid/ready pair.
// The control side holds `orden` (and the physical sensor drives `sensor`);
// the actuator samples both on every rising clock edge and reports the door
// state back on `puertas`, `motor`, `timeout`, `posicion` and `zumbador`,
// all of which change only right after a rising edge (or on reset).
//
// Signals:
//   orden     2  command: 00 none, 01 abrir, 10 cerrar, 11 treated as 00
//   sensor    1  obstruction between the doors
//   puertas   2  door state: 00 CERRADAS, 01 ABIERTAS, 10 ABRIENDO, 11 CERRANDO
//   motor     2  01 drive open, 10 drive close, 00 stop
//   timeout   1  dwell expired while ABIERTAS
//   posicion  W  travel position, 0 = closed, T_RECORRIDO = open
//   zumbador  1  forced-close buzzer
//
// Modports: master = control logic / door model side, slave = actuator.
interface puertas_if #(
  parameter int T_RECORRIDO = 8
);
  localparam int W = $clog2(T_RECORRIDO + 1);

  logic [1:0]   orden;
  logic         sensor;
  logic [1:0]   puertas;
  logic [1:0]   motor;
  logic         timeout;
  logic [W-1:0] posicion;
  logic         zumbador;

  modport master (
    output orden, sensor,
    input  puertas, motor, timeout, posicion, zumbador
  );

  modport slave (
    input  orden, sensor,
    output puertas, motor, timeout, posicion, zumbador
  );
endinterface

// File: rtl/actuador_puertas.sv
// actuador_puertas -- door mechanism actuator, one per car.
//
// Consumes the open/close command from the door control logic, drives the
// door motor, tracks the travel position, times the open dwell and reverses
// the door when the obstruction sensor fires during closing.
//
// Ports:
//   clk                in   system clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   bus_io             slave side of puertas_if (orden/sensor in,
//                      puertas/motor/timeout/posicion/zumbador out)
//   dbg_estado_o       out  FSM state (same encoding as puertas)
//   dbg_reaperturas_o  out  consecutive sensor-reversal counter
//
// Optional feature macro: FORZAR_CIERRE_EN
//   When defined, after MAX_REAPERTURAS sensor reversals the next cerrar is
//   accepted even with the sensor active, the close ignores the sensor and
//   the buzzer sounds until the door is fully closed. When undefined the
//   sensor always reverses and always blocks cerrar, and zumbador stays 0.
module actuador_puertas #(
  parameter int T_RECORRIDO     = 8,
  parameter int T_ESPERA        = 20,
  parameter int MAX_REAPERTURAS = 3,
  localparam int W  = $clog2(T_RECORRIDO + 1),
  localparam int RW = $clog2(MAX_REAPERTURAS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  puertas_if.slave      bus_io,
  output logic [1:0]    dbg_estado_o,
  output logic [RW-1:0] dbg_reaperturas_o
);

  localparam int DW = $clog2(T_ESPERA + 1);

  localparam logic [W-1:0]  POS_MAX   = W'(T_RECORRIDO);
  localparam logic [DW-1:0] DWELL_MAX = DW'(T_ESPERA);
  localparam logic [RW-1:0] REV_MAX   = RW'(MAX_REAPERTURAS);

  // State encoding equals the puertas code, so puertas is the state itself.
  typedef enum logic [1:0] {
    CERRADAS = 2'b00,
    ABIERTAS = 2'b01,
    ABRIENDO = 2'b10,
    CERRANDO = 2'b11
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [W-1:0]  pos_q, pos_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] rev_q, rev_d;
  logic          timeout_q, timeout_d;

  logic abrir, cerrar;
  logic forzado;
  logic sensor_rev;

  // 11 decodes to neither command.
  assign abrir  = (bus_io.orden == 2'b01);
  assign cerrar = (bus_io.orden == 2'b10);

`ifdef FORZAR_CIERRE_EN
  // Reversal budget exhausted: closing may no longer be stopped by the sensor.
  assign forzado = (rev_q == REV_MAX);
`else
  assign forzado = 1'b0;
`endif

  assign sensor_rev = bus_io.sensor && !forzado;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= CERRADAS;
      pos_q     <= '0;
      dwell_q   <= '0;
      rev_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      pos_q     <= pos_d;
      dwell_q   <= dwell_d;
      rev_q     <= rev_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    pos_d    = pos_q;
    dwell_d  = '0;          // dwell only runs inside ABIERTAS
    rev_d    = rev_q;

    case (estado_q)
      CERRADAS: begin
        if (abrir) estado_d = ABRIENDO;
      end

      ABRIENDO: begin
        // Opening always completes; cerrar and sensor are not looked at.
        pos_d = pos_q + W'(1);
        if (pos_q == POS_MAX - W'(1)) estado_d = ABIERTAS;
      end

      ABIERTAS: begin
        if (cerrar && (!bus_io.sensor || forzado)) begin
          estado_d = CERRANDO;
        end else if (bus_io.sensor || abrir) begin
          dwell_d = '0;
        end else if (dwell_q != DWELL_MAX) begin
          dwell_d = dwell_q + DW'(1);
        end else begin
          dwell_d = dwell_q;
        end
      end

      CERRANDO: begin
        if (abrir || sensor_rev) begin
          // Reverse from the current position; sensor+abrir together is
          // one reversal.
          estado_d = ABRIENDO;
          if (sensor_rev && (rev_q != REV_MAX)) rev_d = rev_q + RW'(1);
        end else begin
          pos_d = pos_q - W'(1);
          if (pos_q == W'(1)) begin
            estado_d = CERRADAS;
            rev_d    = '0;
          end
        end
      end

      default: estado_d = CERRADAS;
    endcase

    timeout_d = (estado_d == ABIERTAS) && (dwell_d == DWELL_MAX);
  end

  // Output logic: registered state only
  always_comb begin
    bus_io.puertas  = estado_q;
    bus_io.posicion = pos_q;
    bus_io.timeout  = timeout_q;
    bus_io.motor    = 2'b00;
    bus_io.zumbador = 1'b0;
    case (estado_q)
      ABRIENDO: bus_io.motor = 2'b01;
      CERRANDO: bus_io.motor = 2'b10;
      default:  bus_io.motor = 2'b00;
    endcase
    if (estado_q == CERRANDO) bus_io.zumbador = forzado;
    dbg_estado_o      = estado_q;
    dbg_reaperturas_o = rev_q;
  end

endmodule
